circuito_exp5: RTL and testbench

Memory-game core for the FPGA board: a fixed 16-entry sequence of one-hot 4-bit plays is stored in an internal ROM, and the player must reproduce it on `chaves` one play at a time. The block ends in one of three states: success after 16 correct plays, failure on a mismatch, or failure on timeout. It also drives the debug outputs: 7-segment displays, the clock mirror and the timeout counter.

---
 rtl/circuito_exp5_pkg.sv | 45 ++++
 rtl/circuito_exp5_hexa7seg.sv | 31 +++
 rtl/circuito_exp5.sv | 124 ++++++++++++
 tb/tb_circuito_exp5.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for the memory-game core: state codes, timeout limit
// and the fixed play sequence.
package circuito_exp5_pkg;

    localparam int          N_JOGADAS   = 16;
    localparam logic [11:0] TIMEOUT_MAX = 12'd4095;

    // The encoding doubles as the hex digit shown on db_estado
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hD
    } state_t;

    function automatic logic [3:0] rom_dado(input logic [3:0] endereco);
        logic [3:0] dado;
        case (endereco)
            4'd0:    dado = 4'h1;
            4'd1:    dado = 4'h2;
            4'd2:    dado = 4'h4;
            4'd3:    dado = 4'h8;
            4'd4:    dado = 4'h4;
            4'd5:    dado = 4'h2;
            4'd6:    dado = 4'h1;
            4'd7:    dado = 4'h1;
            4'd8:    dado = 4'h2;
            4'd9:    dado = 4'h2;
            4'd10:   dado = 4'h4;
            4'd11:   dado = 4'h4;
            4'd12:   dado = 4'h8;
            4'd13:   dado = 4'h8;
            4'd14:   dado = 4'h1;
            4'd15:   dado = 4'h4;
            default: dado = 4'h0;
        endcase
        return dado;
    endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to active-low 7-segment pattern, bit order gfedcba.
module hexa7seg (
    input  logic [3:0] hexa_i,
    output logic [6:0] display_o
);

    // Full hex table so unused state codes still render something readable
    always_comb begin
        display_o = 7'b1111111;
        case (hexa_i)
            4'h0:    display_o = 7'b1000000;
            4'h1:    display_o = 7'b1111001;
            4'h2:    display_o = 7'b0100100;
            4'h3:    display_o = 7'b0110000;
            4'h4:    display_o = 7'b0011001;
            4'h5:    display_o = 7'b0010010;
            4'h6:    display_o = 7'b0000010;
            4'h7:    display_o = 7'b1111000;
            4'h8:    display_o = 7'b0000000;
            4'h9:    display_o = 7'b0010000;
            4'hA:    display_o = 7'b0001000;
            4'hB:    display_o = 7'b0000011;
            4'hC:    display_o = 7'b1000110;
            4'hD:    display_o = 7'b0100001;
            4'hE:    display_o = 7'b0000110;
            4'hF:    display_o = 7'b0001110;
            default: display_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_exp5.sv
// Memory-game core: the player reproduces a 16-play ROM sequence on chaves;
// ends in success, mismatch failure or idle timeout.
module circuito_exp5
    import circuito_exp5_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [3:0]  chaves,
    output logic        acertou,
    output logic        errou,
    output logic        pronto,
    output logic [3:0]  leds,
    output logic [6:0]  db_contagem,
    output logic [6:0]  db_memoria,
    output logic [6:0]  db_estado,
    output logic [6:0]  db_jogadafeita,
    output logic        db_clock,
    output logic        db_tem_jogada,
    output logic        db_timeout,
    output logic [11:0] db_Q
);

    state_t      estado_q, estado_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  jogada_q, jogada_d;
    logic [11:0] cnt_q, cnt_d;
    logic        tem_q;
    logic        tem_s;
    logic        pulso_s;
    logic [3:0]  rom_s;
    logic [3:0]  estado_cod_s;

    assign tem_s        = |chaves;
    assign pulso_s      = tem_s & ~tem_q;
    assign rom_s        = rom_dado(addr_q);
    assign estado_cod_s = estado_q;

    // State, datapath registers and the key edge detector
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            addr_q   <= 4'd0;
            jogada_q <= 4'd0;
            cnt_q    <= 12'd0;
            tem_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            jogada_q <= jogada_d;
            cnt_q    <= cnt_d;
            tem_q    <= tem_s;
        end
    end

    // Next-state and datapath control
    always_comb begin
        estado_d = estado_q;
        addr_d   = addr_q;
        jogada_d = jogada_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = INICIAL;
            end
            PREPARACAO: begin
                addr_d   = 4'd0;
                jogada_d = 4'd0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A play in the same cycle as the timeout still counts
                if (pulso_s)                   estado_d = REGISTRA;
                else if (cnt_q == TIMEOUT_MAX) estado_d = FIM_TIMEOUT;
                else                           estado_d = ESPERA;
            end
            REGISTRA: begin
                jogada_d = chaves;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (jogada_q != rom_s)  estado_d = FIM_ERROU;
                else if (addr_q == 4'd15) estado_d = FIM_ACERTOU;
                else                      estado_d = PROXIMO;
            end
            PROXIMO: begin
                addr_d   = addr_q + 4'd1;
                estado_d = ESPERA;
            end
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = estado_q;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Idle counter: any key held resets it; counts only while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (estado_q == PREPARACAO || estado_q == PROXIMO || tem_s) begin
            cnt_d = 12'd0;
        end else if (estado_q == ESPERA && cnt_q != TIMEOUT_MAX) begin
            cnt_d = cnt_q + 12'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign acertou       = (estado_q == FIM_ACERTOU);
    assign errou         = (estado_q == FIM_ERROU) || (estado_q == FIM_TIMEOUT);
    assign pronto        = acertou | errou;
    assign db_timeout    = (estado_q == FIM_TIMEOUT);
    assign leds          = jogada_q;
    assign db_Q          = cnt_q;
    assign db_clock      = clock;
    assign db_tem_jogada = tem_s;

    hexa7seg u_hex_contagem (.hexa_i(addr_q),       .display_o(db_contagem));
    hexa7seg u_hex_memoria  (.hexa_i(rom_s),        .display_o(db_memoria));
    hexa7seg u_hex_estado   (.hexa_i(estado_cod_s), .display_o(db_estado));
    hexa7seg u_hex_jogada   (.hexa_i(jogada_q),     .display_o(db_jogadafeita));

endmodule

// File: tb/tb_circuito_exp5.sv
// Directed self-checking bench for the memory-game core.
module tb_circuito_exp5;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_D = 7'b0100001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic [3:0]  chaves = 4'd0;
    logic        acertou, errou, pronto, db_clock, db_tem_jogada, db_timeout;
    logic [3:0]  leds;
    logic [6:0]  db_contagem, db_memoria, db_estado, db_jogadafeita;
    logic [11:0] db_Q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] seq [16];

    circuito_exp5 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
        .db_clock(db_clock), .db_tem_jogada(db_tem_jogada),
        .db_timeout(db_timeout), .db_Q(db_Q)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic play(input logic [3:0] v, input int hold, input int idle);
        chaves = v;
        tick(hold);
        chaves = 4'd0;
        tick(idle);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick(3);
        iniciar = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++;
        if (db_estado !== SEG_0) begin n_fail++; $display("FAIL reset_estado got %b want %b", db_estado, SEG_0); end
        n_checks++;
        if ({pronto, acertou, errou, db_timeout} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {pronto, acertou, errou, db_timeout}); end
        n_checks++;
        if (db_contagem !== SEG_0) begin n_fail++; $display("FAIL reset_contagem got %b want %b", db_contagem, SEG_0); end
        n_checks++;
        if (db_Q !== 12'd0 || leds !== 4'd0) begin n_fail++; $display("FAIL reset_regs got Q=%0d leds=%h want 0 0", db_Q, leds); end
    endtask

    task automatic test_start();
        iniciar = 1'b1;
        tick(500);
        iniciar = 1'b0;
        tick(1);
        n_checks++;
        if (db_estado !== SEG_2) begin n_fail++; $display("FAIL start_estado got %b want %b", db_estado, SEG_2); end
        n_checks++;
        if (db_contagem !== SEG_0 || db_memoria !== SEG_1) begin n_fail++; $display("FAIL start_addr got cont=%b mem=%b want %b %b", db_contagem, db_memoria, SEG_0, SEG_1); end
    endtask

    task automatic test_plays_idle();
        play(4'b0001, 1000, 1000);
        play(4'b0010, 1000, 1000);
        chaves = 4'b0100;
        tick(1000);
        n_checks++;
        if (db_Q !== 12'd0 || db_tem_jogada !== 1'b1) begin n_fail++; $display("FAIL held_key got Q=%0d tem=%b want 0 1", db_Q, db_tem_jogada); end
        chaves = 4'd0;
        tick(4000);
        n_checks++;
        if (db_contagem !== SEG_3) begin n_fail++; $display("FAIL plays_contagem got %b want %b", db_contagem, SEG_3); end
        n_checks++;
        if (db_Q !== 12'd4000) begin n_fail++; $display("FAIL idle_count got %0d want 4000", db_Q); end
        n_checks++;
        if (errou !== 1'b0 || db_timeout !== 1'b0 || db_estado !== SEG_2) begin n_fail++; $display("FAIL no_timeout got errou=%b to=%b est=%b want 0 0 %b", errou, db_timeout, db_estado, SEG_2); end
    endtask

    task automatic test_mismatch();
        logic seen;
        seen = 1'b0;
        chaves = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (errou === 1'b1) seen = 1'b1;
        end
        tick(1);
        chaves = 4'd0;
        tick(2);
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL mismatch_latency got errou=%b want 1 within 4 cycles", seen); end
        n_checks++;
        if ({pronto, acertou, errou} !== 3'b101) begin n_fail++; $display("FAIL mismatch_flags got %b want 101", {pronto, acertou, errou}); end
        n_checks++;
        if (db_estado !== SEG_E || db_jogadafeita !== SEG_1 || leds !== 4'b0001) begin n_fail++; $display("FAIL mismatch_disp got est=%b jog=%b leds=%b want %b %b 0001", db_estado, db_jogadafeita, leds, SEG_E, SEG_1); end
    endtask

    task automatic test_full_sequence();
        start_game();
        for (int i = 0; i < 16; i++) play(seq[i], 3, 3);
        n_checks++;
        if ({pronto, acertou, errou} !== 3'b110) begin n_fail++; $display("FAIL success_flags got %b want 110", {pronto, acertou, errou}); end
        n_checks++;
        if (db_estado !== SEG_A) begin n_fail++; $display("FAIL success_estado got %b want %b", db_estado, SEG_A); end
        start_game();
        n_checks++;
        if (db_estado !== SEG_2 || db_contagem !== SEG_0 || pronto !== 1'b0) begin n_fail++; $display("FAIL restart got est=%b cont=%b pronto=%b want %b %b 0", db_estado, db_contagem, pronto, SEG_2, SEG_0); end
    endtask

    task automatic test_timeout();
        int waited;
        waited = 0;
        while (db_timeout !== 1'b1 && waited < 4200) begin
            tick(1);
            waited++;
        end
        n_checks++;
        if (db_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_fire got %b want 1 within 4200 cycles", db_timeout); end
        n_checks++;
        if (waited < 4090) begin n_fail++; $display("FAIL timeout_early got %0d cycles want >= 4090", waited); end
        n_checks++;
        if (db_Q !== 12'd4095) begin n_fail++; $display("FAIL timeout_Q got %0d want 4095", db_Q); end
        n_checks++;
        if ({pronto, acertou, errou} !== 3'b101 || db_estado !== SEG_D) begin n_fail++; $display("FAIL timeout_state got flags=%b est=%b want 101 %b", {pronto, acertou, errou}, db_estado, SEG_D); end
    endtask

    task automatic test_reset_in_espera();
        start_game();
        for (int i = 0; i < 5; i++) play(seq[i], 3, 3);
        n_checks++;
        if (db_contagem !== SEG_5 || db_estado !== SEG_2) begin n_fail++; $display("FAIL pre_reset got cont=%b est=%b want %b %b", db_contagem, db_estado, SEG_5, SEG_2); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++;
        if (db_estado !== SEG_0 || db_contagem !== SEG_0) begin n_fail++; $display("FAIL reset_espera got est=%b cont=%b want %b %b", db_estado, db_contagem, SEG_0, SEG_0); end
    endtask

    initial begin
        seq[0]  = 4'h1; seq[1]  = 4'h2; seq[2]  = 4'h4; seq[3]  = 4'h8;
        seq[4]  = 4'h4; seq[5]  = 4'h2; seq[6]  = 4'h1; seq[7]  = 4'h1;
        seq[8]  = 4'h2; seq[9]  = 4'h2; seq[10] = 4'h4; seq[11] = 4'h4;
        seq[12] = 4'h8; seq[13] = 4'h8; seq[14] = 4'h1; seq[15] = 4'h4;
        tick(1);
        test_reset();
        test_start();
        test_plays_idle();
        test_mismatch();
        test_full_sequence();
        test_timeout();
        test_reset_in_espera();
        n_checks++;
        if (db_clock !== clock) begin n_fail++; $display("FAIL db_clock got %b want %b", db_clock, clock); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
